rob_commit: RTL and testbench

// Reorder-buffer retire end of the Tomasulo pipeline: the in-order reader of the ROB that the issue stage fills at tail.

---
 rtl/rob_commit.sv | 153 +++++++++++++++
 tb/tb_rob_commit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Retire end of the reorder buffer: tracks CDB completion per entry, retires the
// head in program order, drives the regbank write and flushes on a mispredicted branch.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispred,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              flush,
    output logic [TAG_W:0]    rob_count
);

    typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [3:0]     BRANCH_C = 4'b0100;
    localparam logic [TAG_W:0] DEPTH_C  = (TAG_W+1)'(DEPTH);

    state_t              state_r, state_nxt_s;
    logic [TAG_W-1:0]    head_r, tail_r;
    logic [TAG_W:0]      count_r;
    logic [DEPTH-1:0]    valid_r, done_r, mispred_r;
    logic [3:0]          func_r [DEPTH];
    logic [REG_W-1:0]    rd_r   [DEPTH];
    logic [DATA_W-1:0]   data_r [DEPTH];

    logic run_s, alloc_acc_s, commit_s, flush_s, cdb_upd_s;

    assign alloc_tag = tail_r;
    assign rob_count = count_r;

    // State register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: a retiring mispredicted branch costs exactly one FLUSH cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN:     state_nxt_s = flush_s ? FLUSH : RUN;
            FLUSH:   state_nxt_s = RUN;
            default: state_nxt_s = RUN;
        endcase
    end

    // Control decodes from registered state; alloc_ready ignores a same-cycle commit
    always_comb begin
        run_s       = (state_r == RUN);
        alloc_ready = run_s && (count_r < DEPTH_C);
        alloc_acc_s = alloc_valid && alloc_ready;
        commit_s    = run_s && (count_r != {(TAG_W+1){1'b0}}) && done_r[head_r];
        flush_s     = commit_s && (func_r[head_r] == BRANCH_C) && mispred_r[head_r];
        cdb_upd_s   = run_s && cdb_valid && valid_r[cdb_tag] && !done_r[cdb_tag]
                      && !(alloc_acc_s && (tail_r == cdb_tag));
    end

    // Entry storage: allocation, CDB completion, retire and flush
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= {DEPTH{1'b0}};
            done_r    <= {DEPTH{1'b0}};
            mispred_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                func_r[i] <= 4'b0000;
                rd_r[i]   <= {REG_W{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (flush_s) begin
            valid_r   <= {DEPTH{1'b0}};
            done_r    <= {DEPTH{1'b0}};
            mispred_r <= {DEPTH{1'b0}};
        end else begin
            if (commit_s) begin
                valid_r[head_r] <= 1'b0;
            end
            if (cdb_upd_s) begin
                done_r[cdb_tag]    <= 1'b1;
                data_r[cdb_tag]    <= cdb_data;
                mispred_r[cdb_tag] <= cdb_mispred;
            end
            if (alloc_acc_s) begin
                valid_r[tail_r]   <= 1'b1;
                done_r[tail_r]    <= 1'b0;
                mispred_r[tail_r] <= 1'b0;
                func_r[tail_r]    <= alloc_func;
                rd_r[tail_r]      <= alloc_rd;
            end
        end
    end

    // Pointers and occupancy; a flush discards any same-edge allocation
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {(TAG_W+1){1'b0}};
        end else if (flush_s) begin
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {(TAG_W+1){1'b0}};
        end else begin
            head_r  <= commit_s    ? head_r + TAG_W'(1) : head_r;
            tail_r  <= alloc_acc_s ? tail_r + TAG_W'(1) : tail_r;
            count_r <= count_r + {{TAG_W{1'b0}}, alloc_acc_s} - {{TAG_W{1'b0}}, commit_s};
        end
    end

    // Registered retire outputs; rd/data/tag hold their last retired values
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_we    <= 1'b0;
            commit_rd    <= {REG_W{1'b0}};
            commit_data  <= {DATA_W{1'b0}};
            commit_tag   <= {TAG_W{1'b0}};
            flush        <= 1'b0;
        end else begin
            commit_valid <= commit_s;
            commit_we    <= commit_s && (func_r[head_r] != BRANCH_C);
            flush        <= flush_s;
            if (commit_s) begin
                commit_rd   <= rd_r[head_r];
                commit_data <= data_r[head_r];
                commit_tag  <= head_r;
            end else begin
                commit_rd   <= commit_rd;
                commit_data <= commit_data;
                commit_tag  <= commit_tag;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic, compared each
// cycle against an in-order queue model of the reorder buffer.
module tb_rob_commit;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        cdb_mispred;
    logic        commit_valid, commit_we, flush;
    logic [3:0]  commit_rd;
    logic [15:0] commit_data;
    logic [2:0]  commit_tag;
    logic [3:0]  rob_count;

    int n_checks = 0;
    int n_pass   = 0;

    rob_commit dut (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_mispred(cdb_mispred),
        .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_tag(commit_tag), .flush(flush), .rob_count(rob_count)
    );

    always #5 clk1 = ~clk1;

    // Reference model: program-ordered queue of live entries
    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  func;
        logic [3:0]  rd;
        bit          done;
        logic [15:0] data;
        bit          mp;
    } ent_t;

    ent_t        q[$];
    int          m_tag;
    bit          m_flush;
    logic        e_cv, e_we, e_fl;
    logic [3:0]  e_rd;
    logic [15:0] e_data;
    logic [2:0]  e_tag;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_tag = 0; m_flush = 1'b0;
        e_cv = 1'b0; e_we = 1'b0; e_fl = 1'b0;
        e_rd = 4'h0; e_data = 16'h0000; e_tag = 3'd0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".alloc_ready"}, 32'(alloc_ready), 32'(!m_flush && q.size() < 8));
        chk({where, ".alloc_tag"}, 32'(alloc_tag), 32'(m_tag));
        chk({where, ".rob_count"}, 32'(rob_count), 32'(q.size()));
        chk({where, ".commit_valid"}, 32'(commit_valid), 32'(e_cv));
        chk({where, ".commit_we"}, 32'(commit_we), 32'(e_we));
        chk({where, ".flush"}, 32'(flush), 32'(e_fl));
        chk({where, ".commit_rd"}, 32'(commit_rd), 32'(e_rd));
        chk({where, ".commit_data"}, 32'(commit_data), 32'(e_data));
        chk({where, ".commit_tag"}, 32'(commit_tag), 32'(e_tag));
    endtask

    // One cycle: drive at negedge, check, clock, update model, check registered outputs
    task automatic step(input logic av, input logic [3:0] f, input logic [3:0] rd,
                        input logic cv, input logic [2:0] ct, input logic [15:0] cd, input logic cm);
        bit   was, acc, did;
        ent_t h;
        alloc_valid = av; alloc_func = f; alloc_rd = rd;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd; cdb_mispred = cm;
        #1;
        check_outputs("pre");
        @(posedge clk1);
        was = m_flush; m_flush = 1'b0;
        acc = av && !was && (q.size() < 8);
        did = !was && (q.size() > 0) && q[0].done;
        if (did) h = q[0];
        if (!was && cv) begin
            foreach (q[i]) if (q[i].tag == ct && !q[i].done) begin
                q[i].done = 1'b1; q[i].data = cd; q[i].mp = cm;
            end
        end
        e_cv = did;
        e_we = did && (h.func != 4'b0100);
        e_fl = did && (h.func == 4'b0100) && h.mp;
        if (did) begin
            e_rd = h.rd; e_data = h.data; e_tag = h.tag;
            void'(q.pop_front());
        end
        if (e_fl) begin
            q.delete(); m_tag = 0; m_flush = 1'b1;
        end else if (acc) begin
            q.push_back('{tag: 3'(m_tag), func: f, rd: rd, done: 1'b0, data: 16'h0000, mp: 1'b0});
            m_tag = (m_tag + 1) % 8;
        end
        #1;
        check_outputs("post");
        @(negedge clk1);
    endtask

    task automatic alloc(input logic [3:0] f, input logic [3:0] rd);
        step(1'b1, f, rd, 1'b0, 3'd0, 16'h0000, 1'b0);
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] d, input logic m);
        step(1'b0, 4'h0, 4'h0, 1'b1, t, d, m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 16'h0000, 1'b0);
    endtask

    task automatic check_reset_values(input string where);
        chk({where, ".rob_count"}, 32'(rob_count), 32'd0);
        chk({where, ".alloc_ready"}, 32'(alloc_ready), 32'd1);
        chk({where, ".alloc_tag"}, 32'(alloc_tag), 32'd0);
        chk({where, ".commit_valid"}, 32'(commit_valid), 32'd0);
        chk({where, ".commit_we"}, 32'(commit_we), 32'd0);
        chk({where, ".commit_rd"}, 32'(commit_rd), 32'd0);
        chk({where, ".commit_data"}, 32'(commit_data), 32'd0);
        chk({where, ".commit_tag"}, 32'(commit_tag), 32'd0);
        chk({where, ".flush"}, 32'(flush), 32'd0);
    endtask

    initial begin
        logic [2:0] ct;
        logic [3:0] f;
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_func = 4'h0; alloc_rd = 4'h0;
        cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'h0000; cdb_mispred = 1'b0;
        model_reset();
        #3;
        check_reset_values("reset");
        @(negedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;

        // Single op
        alloc(4'h0, 4'd5);
        cdb(3'd0, 16'h1234, 1'b0);
        idle(2);

        // In-order retire with reverse completion
        alloc(4'h0, 4'd1); alloc(4'h1, 4'd2); alloc(4'h2, 4'd3);
        cdb(3'd3, 16'h0003, 1'b0); cdb(3'd2, 16'h0002, 1'b0); cdb(3'd1, 16'h0001, 1'b0);
        idle(4);

        // Fill, drop the ninth, retire and wrap
        for (int i = 0; i < 8; i++) alloc(4'h1, 4'(i));
        alloc(4'h0, 4'hf);
        cdb(m_tag[2:0], 16'hbeef, 1'b0);
        idle(1);
        alloc(4'h3, 4'h9);
        for (int i = 1; i <= 8; i++) cdb(3'((m_tag + i) % 8), 16'(16'h1000 + i), 1'b0);
        idle(3);

        // Mispredicted branch
        alloc(4'h4, 4'd0); alloc(4'h0, 4'd7); alloc(4'h2, 4'd8);
        cdb(3'((m_tag + 6) % 8), 16'h0aaa, 1'b0);
        cdb(3'((m_tag + 7) % 8), 16'h0bbb, 1'b0);
        cdb(3'((m_tag + 5) % 8), 16'h0ccc, 1'b1);
        alloc(4'h0, 4'd2);
        alloc(4'h0, 4'd3);
        idle(3);

        // Correctly predicted branch retires without write or flush
        alloc(4'h4, 4'd6);
        cdb(3'((m_tag + 7) % 8), 16'h0ddd, 1'b0);
        idle(2);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if (q.size() > 0 && $urandom_range(0, 9) < 7) ct = q[$urandom_range(0, q.size() - 1)].tag;
            else ct = 3'($urandom_range(0, 7));
            f = 4'($urandom_range(0, 4));
            step(1'($urandom_range(0, 9) < 6), f, 4'($urandom),
                 1'($urandom_range(0, 9) < 6), ct, 16'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        // Async reset with five live entries
        rst_n = 1'b0; #3; model_reset();
        @(negedge clk1); rst_n = 1'b1;
        alloc(4'h0, 4'd3);
        cdb(3'd0, 16'h5a5a, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) alloc(4'h1, 4'(i + 1));
        chk("five_live.rob_count", 32'(rob_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk1);
        rst_n = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
